// File: rtl/mips_exec_pkg.sv
// -----------------------------------------------------------------------------
// mips_exec_pkg
//   Shared constants for the MIPS execute stage:
//   - 3-bit ALU operation codes driven onto alu_ctl
//   - 2-bit ALUOp encodings produced by main control
//   - R-type funct[3:0] encodings recognised by the ALU control decode
// -----------------------------------------------------------------------------
package mips_exec_pkg;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUOp encodings from main control (aluop1 set means "look at funct")
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  // R-type funct[3:0] encodings
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_AND = 4'b0100;
  localparam logic [3:0] FUNCT_OR  = 4'b0101;
  localparam logic [3:0] FUNCT_SLT = 4'b1010;

  // ALU control decode: ALUOp plus funct bits -> ALU operation code.
  // Any ALUOp with bit 1 set is treated as R-type; unknown funct falls
  // back to add.
  function automatic logic [2:0] alu_decode(input logic [1:0] aluop,
                                            input logic [3:0] funct);
    logic [2:0] ctl;
    ctl = ALU_ADD;
    if (aluop == ALUOP_ADD) begin
      ctl = ALU_ADD;
    end else if (aluop == ALUOP_SUB) begin
      ctl = ALU_SUB;
    end else begin
      case (funct)
        FUNCT_ADD: ctl = ALU_ADD;
        FUNCT_SUB: ctl = ALU_SUB;
        FUNCT_AND: ctl = ALU_AND;
        FUNCT_OR:  ctl = ALU_OR;
        FUNCT_SLT: ctl = ALU_SLT;
        default:   ctl = ALU_ADD;
      endcase
    end
    return ctl;
  endfunction

endpackage

// File: rtl/exec_adder32.sv
// -----------------------------------------------------------------------------
// exec_adder32
//   Combinational adder, modulo 2^WIDTH (carry out discarded).
//   Ports:
//     a   - addend
//     b   - addend
//     sum - a + b, wrapping
// -----------------------------------------------------------------------------
module exec_adder32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mips_exec_stage.sv
// -----------------------------------------------------------------------------
// mips_exec_stage
//   Registered execute stage: ALU control decode, 32-bit ALU, PC+4 and
//   branch target. All results land in one output register, 1-cycle latency.
//   Ports:
//     clk, rst_n     - clock, asynchronous active-low reset (clears outputs)
//     valid_in       - capture enable; when low every output register holds
//     aluop, funct   - ALU control inputs
//     a, b           - ALU operands
//     pc, imm_ext    - program counter and sign-extended immediate
//     alu_ctl        - registered ALU operation code
//     result, zero   - registered ALU result and (result == 0)
//     pc_plus4       - registered pc + 4
//     branch_target  - registered pc + 4 + (imm_ext << 2)
//     valid_out      - registered valid_in (holds when valid_in is low)
//   There is no backpressure: valid_in is a plain capture enable and
//   valid_out simply reports whether the last capture was a valid one.
// -----------------------------------------------------------------------------
module mips_exec_stage
  import mips_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [1:0]       aluop,
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm_ext,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] branch_target,
  output logic             valid_out
);

  // Next-state values
  logic [2:0]       alu_ctl_d;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic [WIDTH-1:0] pc_plus4_d;
  logic [WIDTH-1:0] branch_target_d;

  // Registers
  logic [2:0]       alu_ctl_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic [WIDTH-1:0] branch_target_q;
  logic             valid_q;

  // Word-aligned branch offset; the top two immediate bits shift out.
  logic [WIDTH-1:0] branch_offset;
  assign branch_offset = {imm_ext[WIDTH-3:0], 2'b00};

  exec_adder32 #(.WIDTH(WIDTH)) u_pc_adder (
    .a   (pc),
    .b   (WIDTH'(4)),
    .sum (pc_plus4_d)
  );

  exec_adder32 #(.WIDTH(WIDTH)) u_branch_adder (
    .a   (pc_plus4_d),
    .b   (branch_offset),
    .sum (branch_target_d)
  );

  // ALU control decode
  always_comb begin
    alu_ctl_d = alu_decode(aluop, funct);
  end

  // ALU datapath. slt uses a true signed compare rather than the sign of
  // a-b, so it stays correct when the subtraction overflows.
  always_comb begin
    result_d = '0;
    case (alu_ctl_d)
      ALU_AND: result_d = a & b;
      ALU_OR:  result_d = a | b;
      ALU_ADD: result_d = a + b;
      ALU_SUB: result_d = a - b;
      ALU_SLT: result_d = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: result_d = '0;
    endcase
  end

  // Zero flag follows the selected operation's result.
  assign zero_d = (result_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctl_q       <= 3'b000;
      result_q        <= '0;
      zero_q          <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
      valid_q         <= 1'b0;
    end else if (valid_in) begin
      alu_ctl_q       <= alu_ctl_d;
      result_q        <= result_d;
      zero_q          <= zero_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
      valid_q         <= 1'b1;
    end
  end

  assign alu_ctl       = alu_ctl_q;
  assign result        = result_q;
  assign zero          = zero_q;
  assign pc_plus4      = pc_plus4_q;
  assign branch_target = branch_target_q;
  assign valid_out     = valid_q;

endmodule

// File: tb/tb_mips_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_exec_stage
//   Directed vectors with hand-computed expectations. The driver pushes the
//   expected output bundle {valid_out, alu_ctl, result, zero, pc_plus4,
//   branch_target} for every clock it drives; the monitor pops and compares
//   on the following falling edge.
// -----------------------------------------------------------------------------
module tb_mips_exec_stage;

  localparam int W = 1 + 3 + 32 + 1 + 32 + 32;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [1:0]  aluop;
  logic [3:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] pc;
  logic [31:0] imm_ext;
  logic [2:0]  alu_ctl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic        valid_out;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  int           n_checks;
  int           n_fails;

  mips_exec_stage #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .aluop         (aluop),
    .funct         (funct),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .imm_ext       (imm_ext),
    .alu_ctl       (alu_ctl),
    .result        (result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .valid_out     (valid_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] outs();
    return {valid_out, alu_ctl, result, zero, pc_plus4, branch_target};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input string name,
                       input logic [1:0] op, input logic [3:0] fn,
                       input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] tpc, input logic [31:0] timm,
                       input logic [2:0] e_ctl, input logic [31:0] e_res,
                       input logic e_zero, input logic [31:0] e_pc4,
                       input logic [31:0] e_bt);
    @(negedge clk);
    valid_in = 1'b1;
    aluop    = op;
    funct    = fn;
    a        = ta;
    b        = tb_v;
    pc       = tpc;
    imm_ext  = timm;
    @(posedge clk);
    #1;
    last_exp = {1'b1, e_ctl, e_res, e_zero, e_pc4, e_bt};
    exp_q.push_back(last_exp);
    $display("issued %s", name);
  endtask

  // valid_in low with scrambled inputs: outputs must not move.
  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      aluop    = 2'($urandom_range(0, 3));
      funct    = 4'($urandom_range(0, 15));
      a        = $urandom;
      b        = $urandom;
      pc       = $urandom;
      imm_ext  = $urandom;
      @(posedge clk);
      #1;
      exp_q.push_back(last_exp);
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL drain_timeout: %0d entries left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_state(input string name);
    n_checks++;
    if (outs() !== '0) begin
      n_fails++;
      $display("FAIL %s: got %h required all zero", name, outs());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (outs() !== e) begin
        n_fails++;
        $display("FAIL outputs: got v=%b ctl=%b res=%h z=%b pc4=%h bt=%h required v=%b ctl=%b res=%h z=%b pc4=%h bt=%h",
                 valid_out, alu_ctl, result, zero, pc_plus4, branch_target,
                 e[100], e[99:97], e[96:65], e[64], e[63:32], e[31:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fails  = 0;
    last_exp = '0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    aluop    = 2'b00;
    funct    = 4'b0000;
    a        = '0;
    b        = '0;
    pc       = '0;
    imm_ext  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue("add_5_3", 2'b00, 4'b1111, 32'd5, 32'd3, 32'h100, 32'h1,
          3'b010, 32'd8, 1'b0, 32'h104, 32'h108);
    issue("sub_zero", 2'b01, 4'b0000, 32'h1234, 32'h1234, 32'h200, 32'h0,
          3'b110, 32'h0, 1'b1, 32'h204, 32'h204);
    issue("r_and", 2'b10, 4'b0100, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h10, 32'hFFFF_FFFE,
          3'b000, 32'h00F0_0000, 1'b0, 32'h14, 32'h0C);
    issue("r_or", 2'b10, 4'b0101, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'hFFFF_FFFC, 32'h0,
          3'b001, 32'hFFF0_FFFF, 1'b0, 32'h0, 32'h0);
    issue("r_unknown_add", 2'b10, 4'b1111, 32'hF0F0_0000, 32'h0FF0_FFFF, 32'h0, 32'h0,
          3'b010, 32'h00E0_FFFF, 1'b0, 32'h4, 32'h4);
    issue("r_sub", 2'b10, 4'b0010, 32'd10, 32'd3, 32'h0, 32'h0,
          3'b110, 32'd7, 1'b0, 32'h4, 32'h4);
    issue("slt_neg1_1", 2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
          3'b111, 32'd1, 1'b0, 32'h4, 32'h4);
    issue("slt_max_min", 2'b10, 4'b1010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0,
          3'b111, 32'd0, 1'b1, 32'h4, 32'h4);
    issue("slt_min_max", 2'b10, 4'b1010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0,
          3'b111, 32'd1, 1'b0, 32'h4, 32'h4);
    issue("add_wrap", 2'b00, 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0,
          3'b010, 32'd0, 1'b1, 32'h4, 32'h4);
    issue("aluop11_and", 2'b11, 4'b0100, 32'hFF, 32'h0F, 32'h1000, 32'h10,
          3'b000, 32'h0F, 1'b0, 32'h1004, 32'h1044);
    issue("r_add", 2'b10, 4'b0000, 32'd100, 32'hFFFF_FFFF, 32'h2000, 32'hFFFF_FFFF,
          3'b010, 32'd99, 1'b0, 32'h2004, 32'h2000);
    hold_cycles(3);
    drain();

    // Asynchronous reset between edges: outputs clear with no clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_reset_mid_stream");
    @(posedge clk);
    #1;
    check_reset_state("reset_held_over_edge");
    @(negedge clk);
    rst_n = 1'b1;
    last_exp = '0;
    hold_cycles(1);
    issue("add_after_reset", 2'b00, 4'b0000, 32'd5, 32'd3, 32'h40, 32'h2,
          3'b010, 32'd8, 1'b0, 32'h44, 32'h4C);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
